// File: rtl/mips_lite_pkg.sv
// rtl/mips_lite_pkg.sv - shared fetch-stage types and constants
package mips_lite_pkg;

  localparam int unsigned DATA_W = 32;
  localparam logic [DATA_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [1:0] ALIGN_MASK = 2'b00;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_HOLD = 2'd2,
    FETCH_ERR  = 2'd3
  } fetch_state_e;

  // A pc is usable only if it is word aligned
  function automatic logic is_aligned(input logic [DATA_W-1:0] addr);
    return (addr[1:0] == ALIGN_MASK);
  endfunction

endpackage

// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - pc register and single-outstanding instruction fetch
module pc_fetch
  import mips_lite_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  input  logic [DATA_W-1:0] npc,
  output logic [DATA_W-1:0] pc,
  output logic              imem_req,
  output logic [DATA_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              misalign_err,
  output logic [DATA_W-1:0] fetch_cnt
);

  fetch_state_e state;

  // The request address is the pc itself; it only changes on an accept edge,
  // so it is stable for the whole life of a request.
  assign imem_addr = pc;

  // Fetch FSM; imem_req is kept as a register that mirrors state==FETCH_REQ
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= FETCH_IDLE;
      pc           <= RESET_PC;
      imem_req     <= 1'b0;
      instr        <= '0;
      instr_valid  <= 1'b0;
      misalign_err <= 1'b0;
      fetch_cnt    <= '0;
    end else begin
      case (state)
        FETCH_IDLE: begin
          if (fetch_en) begin
            state    <= FETCH_REQ;
            imem_req <= 1'b1;
          end
        end
        FETCH_REQ: begin
          // fetch_en is deliberately not looked at: a request always completes
          if (imem_ack) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= FETCH_HOLD;
          end
        end
        FETCH_HOLD: begin
          if (instr_ready && instr_valid) begin
            pc          <= npc;
            instr_valid <= 1'b0;
            fetch_cnt   <= fetch_cnt + 32'd1;
            if (!is_aligned(npc)) begin
              // pc still takes the bad value so it can be inspected
              misalign_err <= 1'b1;
              state        <= FETCH_ERR;
            end else if (fetch_en) begin
              imem_req <= 1'b1;
              state    <= FETCH_REQ;
            end else begin
              state <= FETCH_IDLE;
            end
          end
        end
        FETCH_ERR: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
        default: begin
          state    <= FETCH_IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// tb/tb_pc_fetch.sv - directed tests for pc_fetch
module tb_pc_fetch;

  logic        clk;
  logic        rst_n;
  logic        fetch_en;
  logic [31:0] npc;
  logic [31:0] pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        misalign_err;
  logic [31:0] fetch_cnt;

  logic        ack_auto;
  logic        ack_man;
  logic        npc_ovr_en;
  logic [31:0] npc_ovr;

  int tests;
  int fails;

  pc_fetch #(.RESET_PC(32'h0000_3000)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .fetch_en(fetch_en),
    .npc(npc),
    .pc(pc),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .instr(instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .misalign_err(misalign_err),
    .fetch_cnt(fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: data word is a recognisable function of the address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  assign imem_rdata = mem_word(imem_addr);
  assign imem_ack   = ack_auto ? imem_req : ack_man;
  assign npc        = npc_ovr_en ? npc_ovr : pc + 32'd4;

  task automatic do_reset();
    @(negedge clk);
    rst_n       = 1'b0;
    fetch_en    = 1'b0;
    ack_auto    = 1'b0;
    ack_man     = 1'b0;
    instr_ready = 1'b0;
    npc_ovr_en  = 1'b0;
    npc_ovr     = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (imem_addr !== 32'h3000 || imem_req !== 1'b0) begin fails++; $display("FAIL reset_outputs: addr=%h req=%b want addr=3000 req=0", imem_addr, imem_req); end
    fetch_en = 1'b1;
    @(negedge clk);
    tests++; if (imem_req !== 1'b1) begin fails++; $display("FAIL reset_pre_req: got %b want 1", imem_req); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL reset_async_req: got %b want 0", imem_req); end
    tests++; if (pc !== 32'h3000 || instr_valid !== 1'b0 || fetch_cnt !== 32'h0 || misalign_err !== 1'b0) begin fails++; $display("FAIL reset_state: pc=%h valid=%b cnt=%h err=%b want 3000 0 0 0", pc, instr_valid, fetch_cnt, misalign_err); end
    tests++; if (instr !== 32'h0) begin fails++; $display("FAIL reset_instr: got %h want 0", instr); end
    fetch_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_straight_line();
    logic [31:0] exp_addr;
    do_reset();
    ack_auto    = 1'b1;
    instr_ready = 1'b1;
    fetch_en    = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      exp_addr = 32'h3000 + 32'(4 * (i / 2));
      tests++;
      if (imem_req !== ((i % 2) == 0) || instr_valid !== ((i % 2) == 1) || imem_addr !== exp_addr) begin
        fails++;
        $display("FAIL straight_cyc%0d: req=%b valid=%b addr=%h want req=%b valid=%b addr=%h", i, imem_req, instr_valid, imem_addr, (i % 2) == 0, (i % 2) == 1, exp_addr);
      end
    end
    tests++; if (instr !== mem_word(32'h3008) || fetch_cnt !== 32'd2) begin fails++; $display("FAIL straight_end: instr=%h cnt=%0d want %h 2", instr, fetch_cnt, mem_word(32'h3008)); end
    fetch_en = 1'b0;
  endtask

  task automatic test_wait_stall();
    do_reset();
    fetch_en = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h3000 || instr_valid !== 1'b0) begin fails++; $display("FAIL wait_cyc%0d: req=%b addr=%h valid=%b want 1 3000 0", i, imem_req, imem_addr, instr_valid); end
      if (i == 2) ack_man = 1'b1;
      @(negedge clk);
    end
    ack_man = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tests++; if (instr_valid !== 1'b1 || instr !== mem_word(32'h3000) || imem_req !== 1'b0) begin fails++; $display("FAIL stall_cyc%0d: valid=%b instr=%h req=%b want 1 %h 0", i, instr_valid, instr, imem_req, mem_word(32'h3000)); end
      @(negedge clk);
    end
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    tests++; if (instr_valid !== 1'b0 || pc !== 32'h3004 || imem_req !== 1'b1 || fetch_cnt !== 32'd1) begin fails++; $display("FAIL stall_accept: valid=%b pc=%h req=%b cnt=%0d want 0 3004 1 1", instr_valid, pc, imem_req, fetch_cnt); end
    fetch_en = 1'b0;
  endtask

  task automatic test_branch();
    do_reset();
    ack_auto = 1'b1;
    fetch_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tests++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL branch_hold: valid=%b want 1", instr_valid); end
    npc_ovr    = 32'h3040;
    npc_ovr_en = 1'b1;
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    npc_ovr_en  = 1'b0;
    tests++; if (imem_addr !== 32'h3040 || imem_req !== 1'b1 || fetch_cnt !== 32'd1 || misalign_err !== 1'b0) begin fails++; $display("FAIL branch_target: addr=%h req=%b cnt=%0d err=%b want 3040 1 1 0", imem_addr, imem_req, fetch_cnt, misalign_err); end
    @(negedge clk);
    tests++; if (instr !== mem_word(32'h3040) || instr_valid !== 1'b1) begin fails++; $display("FAIL branch_instr: instr=%h valid=%b want %h 1", instr, instr_valid, mem_word(32'h3040)); end
    fetch_en = 1'b0;
  endtask

  task automatic test_misalign();
    do_reset();
    ack_auto = 1'b1;
    fetch_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    npc_ovr     = 32'h3042;
    npc_ovr_en  = 1'b1;
    instr_ready = 1'b1;
    @(negedge clk);
    npc_ovr_en  = 1'b0;
    tests++; if (misalign_err !== 1'b1 || pc !== 32'h3042 || imem_req !== 1'b0 || instr_valid !== 1'b0 || fetch_cnt !== 32'd1) begin fails++; $display("FAIL misalign_hit: err=%b pc=%h req=%b valid=%b cnt=%0d want 1 3042 0 0 1", misalign_err, pc, imem_req, instr_valid, fetch_cnt); end
    ack_auto = 1'b0;
    ack_man  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || misalign_err !== 1'b1 || fetch_cnt !== 32'd1) begin fails++; $display("FAIL misalign_sticky%0d: req=%b valid=%b err=%b cnt=%0d want 0 0 1 1", i, imem_req, instr_valid, misalign_err, fetch_cnt); end
    end
    do_reset();
    tests++; if (misalign_err !== 1'b0 || pc !== 32'h3000) begin fails++; $display("FAIL misalign_clear: err=%b pc=%h want 0 3000", misalign_err, pc); end
  endtask

  task automatic test_fetch_en_low();
    do_reset();
    fetch_en = 1'b1;
    @(negedge clk);
    fetch_en = 1'b0;
    @(negedge clk);
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h3000) begin fails++; $display("FAIL noabort_req: req=%b addr=%h want 1 3000", imem_req, imem_addr); end
    ack_man = 1'b1;
    @(negedge clk);
    ack_man = 1'b0;
    tests++; if (instr_valid !== 1'b1 || instr !== mem_word(32'h3000)) begin fails++; $display("FAIL noabort_instr: valid=%b instr=%h want 1 %h", instr_valid, instr, mem_word(32'h3000)); end
    force dut.fetch_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.fetch_cnt;
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    tests++; if (fetch_cnt !== 32'h0 || instr_valid !== 1'b0 || pc !== 32'h3004) begin fails++; $display("FAIL wrap_cnt: cnt=%h valid=%b pc=%h want 0 0 3004", fetch_cnt, instr_valid, pc); end
    for (int i = 0; i < 3; i++) begin
      tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL idle_req%0d: got %b want 0", i, imem_req); end
      @(negedge clk);
    end
  endtask

  initial begin
    tests       = 0;
    fails       = 0;
    rst_n       = 1'b0;
    fetch_en    = 1'b0;
    ack_auto    = 1'b0;
    ack_man     = 1'b0;
    instr_ready = 1'b0;
    npc_ovr_en  = 1'b0;
    npc_ovr     = 32'h0;
    test_reset();
    test_straight_line();
    test_wait_stall();
    test_branch();
    test_misalign();
    test_fetch_en_low();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
